// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and memory-side signals for the unified
// memory port arbiter. The arbiter takes the slave view; the requesters
// plus the memory together form the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch
// (IF) and the load/store unit (DM). One access at a time: sample requests
// in IDLE, issue one command cycle, wait out the fixed read latency, then
// pulse the winner's ack. DM wins contention until it has taken
// MAX_DATA_STREAK contested grants in a row, then a waiting IF gets through.
module mem_port_arbiter #(
    parameter int ADDR_W          = 14,
    parameter int DATA_W          = 32,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        streak_r;
    logic [3:0]        streak_s;
    logic              win_dm_r;
    logic              lat_we_r;
    logic              gnt_s;
    logic              gnt_dm_s;
    logic              gnt_we_s;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_ack_r;
    logic              dm_ack_r;

    // Pick the winner among the requests seen this cycle; only acted on in IDLE
    always_comb begin
        gnt_s    = 1'b0;
        gnt_dm_s = 1'b0;
        streak_s = streak_r;
        if (state_r == IDLE) begin
            if (bus.if_req && bus.dm_req) begin
                gnt_s = 1'b1;
                if (streak_r < STREAK_MAX) begin
                    gnt_dm_s = 1'b1;
                    streak_s = streak_r + 4'd1;
                end else begin
                    gnt_dm_s = 1'b0;
                    streak_s = 4'd0;
                end
            end else if (bus.if_req) begin
                gnt_s    = 1'b1;
                gnt_dm_s = 1'b0;
                streak_s = 4'd0;
            end else if (bus.dm_req) begin
                gnt_s    = 1'b1;
                gnt_dm_s = 1'b1;
                streak_s = streak_r;
            end else begin
                gnt_s    = 1'b0;
                gnt_dm_s = 1'b0;
            end
        end else begin
            gnt_s    = 1'b0;
            gnt_dm_s = 1'b0;
        end
        gnt_we_s = gnt_dm_s & bus.dm_we;
    end

    // Next-state logic of the access sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s) begin
                    state_s = CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (lat_we_r) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant bookkeeping: winner id, latched direction, DM streak, latency count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_dm_r <= 1'b0;
            lat_we_r <= 1'b0;
            streak_r <= 4'd0;
            cnt_r    <= 4'd0;
        end else begin
            if (gnt_s) begin
                win_dm_r <= gnt_dm_s;
                lat_we_r <= gnt_we_s;
                streak_r <= streak_s;
            end
            if (state_r == CMD) begin
                cnt_r <= LAT_LAST;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Memory command, read-data capture and ack pulses, all registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
        end else begin
            // The command registers double as the address/data latch so
            // mem_addr/mem_wdata simply hold after the command cycle.
            mem_en_r <= gnt_s;
            mem_we_r <= gnt_we_s;
            if (gnt_s) begin
                mem_addr_r <= gnt_dm_s ? bus.dm_addr : bus.if_addr;
                if (gnt_dm_s) begin
                    mem_wdata_r <= bus.dm_wdata;
                end
            end
            if ((state_r == WAIT) && (cnt_r == 4'd0)) begin
                if (win_dm_r) begin
                    dm_rdata_r <= bus.mem_rdata;
                end else begin
                    if_rdata_r <= bus.mem_rdata;
                end
            end
            if_ack_r <= (state_s == RESP) && !win_dm_r;
            dm_ack_r <= (state_s == RESP) && win_dm_r;
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.dm_ack    = dm_ack_r;
    assign bus.stall_if  = bus.if_req & ~if_ack_r;
    assign bus.stall_mem = bus.dm_req & ~dm_ack_r;
    assign bus.busy      = (state_r != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported unified memory of the MIPS32 core.
- Two requesters share it: instruction fetch (IF) and the MEM-stage load/store unit (DM).
- Grants one access at a time, issues the memory command and counts the fixed memory latency.
- Returns read data with a one-cycle ack pulse and drives per-stage stall lines into the pipeline control.

Parameters:
ADDR_W, 14, word address width (matches memAddr)
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en cycle to valid mem_rdata; legal range 1..15
MAX_DATA_STREAK, 4, contested DM grants allowed before a pending IF must win; legal range 1..15

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF read request; held until if_ack
if_addr  in  ADDR_W  IF word address
if_ack  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction (registered)
dm_req  in  1  DM request; held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  DM word address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse; load data valid / store done
dm_rdata  out  DATA_W  load data (registered)
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_if  out  1  if_req & ~if_ack
stall_mem  out  1  dm_req & ~dm_ack
busy  out  1  state != IDLE

Behaviour:
- Reset: clk and rst; rst is asynchronous, active-low.
  - While rst=0: state IDLE, streak=0.
  - All registered outputs (acks, rdata registers, mem_*) are 0 immediately, without waiting for a clock edge.
  - Any in-flight transaction is abandoned and no ack is produced; whether an in-flight store was committed is the memory's concern.
- FSM states: IDLE, CMD, WAIT, RESP.
  - IDLE: requests are sampled only here. With any req, pick a winner and latch its addr/we/wdata plus the winner id; go to CMD.
  - CMD: mem_en=1 and mem_we=latched we for exactly this cycle; mem_addr/mem_wdata driven from the latch.
    - Store: go to RESP.
    - Load: go to WAIT with cnt=MEM_LAT-1.
  - WAIT: occupies exactly MEM_LAT cycles. In the last one (cnt==0), capture mem_rdata into the winner's rdata register; go to RESP.
  - RESP: the winner's ack=1 for this cycle only; go to IDLE unconditionally.
- mem_en and mem_we are 0 outside CMD; mem_addr and mem_wdata hold their last value.
- Latency, req first seen high in IDLE at T0:
  - Load: ack at T0+MEM_LAT+2 (MEM_LAT=2 gives T4).
  - Store: ack at T0+2.
- Arbitration in IDLE:
  - Only one req high: grant it.
  - Both high and streak<MAX_DATA_STREAK: grant DM, streak++.
  - Both high and streak==MAX_DATA_STREAK: grant IF, streak=0.
  - Any IF grant clears streak. An uncontested DM grant leaves streak unchanged.
- Handshake:
  - Requesters may keep req high during the ack cycle. A req still high in the following IDLE cycle is a new request.
  - Inputs changing after the grant have no effect on the current transaction.
  - Dropping req before ack is a protocol violation: the transaction still completes and the ack still pulses.
- Outputs:
  - if_ack and dm_ack are never high in the same cycle.
  - if_rdata changes only on IF loads.
  - dm_rdata changes only on DM loads; stores leave it unchanged.
- stall_if and stall_mem are combinational from req and ack.

Test Plan:
1. Reset: rst=0 mid-run → all outputs 0 and busy=0 with no clock edge. After release, the first request is served normally.
2. IF load, MEM_LAT=2, if_addr=0x0010, memory model returns 0x20080005.
   - mem_en=1 with mem_addr=0x0010 at T1.
   - if_ack=1 at T4 with if_rdata=0x20080005.
   - stall_if high T0..T3, low at T4.
3. DM store, dm_addr=0x0100, dm_wdata=0xDEADBEEF.
   - mem_en=mem_we=1 with that addr/data at T1.
   - dm_ack at T2; dm_rdata unchanged.
4. Contention, MAX_DATA_STREAK=4: if_req held high, DM re-requests a load every IDLE → grant order D,D,D,D,I,D,D,D,D,I. if_ack and dm_ack never coincide.
5. Async reset asserted during WAIT of a DM load → no dm_ack. After release, a DM load of addr 0x0004 returns the model's value with normal T4 latency.
6. dm_req rises during RESP of an IF load → DM granted in the next IDLE cycle (not earlier); mem_en for DM exactly 2 cycles after the if_ack cycle.
